imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared processor definitions: instruction-memory geometry and loader state encoding.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W    = 8;
    localparam int IMEM_MAX_WORDS = (1 << IMEM_ADDR_W) / 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Serial program loader: length byte, 4N big-endian payload bytes, XOR checksum byte.
// Each payload byte is written to imem one cycle after acceptance; in_ready drops outside an active load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int LEN_W = ADDR_W - 1;

    ld_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        acc_q, acc_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              last_byte;
    logic [LEN_W-1:0]  len_m1;

    // The byte counter stops at 4N-1 rather than stepping past it, so N=MAX_WORDS never wraps.
    assign len_m1    = len_q - LEN_W'(1);
    assign last_byte = (addr_q[ADDR_W-1:2] == len_m1[ADDR_W-3:0]) && (addr_q[1:0] == 2'b11);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        words_d  = words_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        in_ready = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (accept) begin
                    if ((in_data == 8'd0) || (int'(in_data) > MAX_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = LEN_W'(in_data);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    acc_d   = acc_q ^ in_data;
                    if (addr_q[1:0] == 2'b11) begin
                        words_d = words_q + LEN_W'(1);
                    end
                    if (last_byte) begin
                        state_d = S_CHK;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Hold the core until the last payload write has actually reached memory.
    assign cpu_hold     = in_ready || we_q;
    assign mem_we       = we_q;
    assign mem_addr     = waddr_q;
    assign mem_wdata    = wdata_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected write streams and flags are hand-computed per step.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [6:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_addr [0:1023];
    logic [7:0] wr_data [0:1023];
    int         wr_n = 0;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_n < 1024) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $error("FAIL in_ready_timeout: observed in_ready=%0b expected 1", in_ready);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"},    32'(mem_wdata),32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    initial begin
        int base;
        int bad;
        logic [7:0] pay [0:7];

        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word, good checksum: 12^34^56^78 = 08
        base = wr_n;
        pulse_start();
        @(negedge clk);
        check("t1_in_ready_len", 32'(in_ready), 32'd1);
        check("t1_cpu_hold_len", 32'(cpu_hold), 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        @(negedge clk);
        check("t1_final_we",   32'(mem_we),   32'd1);
        check("t1_final_addr", 32'(mem_addr), 32'd3);
        check("t1_final_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h08, 0);
        @(negedge clk);
        check("t1_nwrites", 32'(wr_n - base), 32'd4);
        check("t1_w0", {wr_addr[base],   wr_data[base]},   {8'h00, 8'h12});
        check("t1_w1", {wr_addr[base+1], wr_data[base+1]}, {8'h01, 8'h34});
        check("t1_w2", {wr_addr[base+2], wr_data[base+2]}, {8'h02, 8'h56});
        check("t1_w3", {wr_addr[base+3], wr_data[base+3]}, {8'h03, 8'h78});
        check("t1_done",  32'(done), 32'd1);
        check("t1_err",   32'(err),  32'd0);
        check("t1_words", 32'(words_loaded), 32'd1);
        check("t1_hold",  32'(cpu_hold), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd0);

        // Zero length goes straight to ERR without writes
        base = wr_n;
        pulse_start();
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t2_err",     32'(err),  32'd1);
        check("t2_done",    32'(done), 32'd0);
        check("t2_ready",   32'(in_ready), 32'd0);
        check("t2_nwrites", 32'(wr_n - base), 32'd0);
        pulse_start();
        @(negedge clk);
        check("t2_restart_ready", 32'(in_ready), 32'd1);
        check("t2_restart_err",   32'(err), 32'd0);

        // Two words with random gaps and a bad checksum (true XOR is 08)
        base = wr_n;
        for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
        send_byte(8'h02, 1);
        for (int i = 0; i < 8; i++) send_byte(pay[i], $urandom_range(0, 3));
        send_byte(8'h55, 2);
        @(negedge clk);
        check("t3_nwrites", 32'(wr_n - base), 32'd8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== pay[i]) bad++;
        check("t3_write_stream", 32'(bad), 32'd0);
        check("t3_err",   32'(err),  32'd1);
        check("t3_done",  32'(done), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd2);

        // Full memory: 64 words, data = address, XOR of 0..255 is 00
        base = wr_n;
        pulse_start();
        send_byte(8'h40, 0);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t4_nwrites", 32'(wr_n - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== 8'(i)) bad++;
        check("t4_write_stream", 32'(bad), 32'd0);
        check("t4_last_addr", 32'(wr_addr[wr_n-1]), 32'hFF);
        check("t4_done",  32'(done), 32'd1);
        check("t4_words", 32'(words_loaded), 32'd64);

        // Length above MAX_WORDS is rejected
        base = wr_n;
        pulse_start();
        send_byte(8'h41, 0);
        @(negedge clk);
        check("t5_err",     32'(err), 32'd1);
        check("t5_nwrites", 32'(wr_n - base), 32'd0);

        // start during DATA is ignored: AA^BB^CC^DD = 00
        base = wr_n;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        pulse_start();
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 1);
        send_byte(8'hDD, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t6_nwrites", 32'(wr_n - base), 32'd4);
        check("t6_w0", {wr_addr[base],   wr_data[base]},   {8'h00, 8'hAA});
        check("t6_w3", {wr_addr[base+3], wr_data[base+3]}, {8'h03, 8'hDD});
        check("t6_done", 32'(done), 32'd1);
        check("t6_err",  32'(err),  32'd0);

        // Reset after the 3rd payload byte, racing a 4th byte and a start
        base = wr_n;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        @(negedge clk);
        check("t7_third_we", 32'(mem_we), 32'd1);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("t7_after_rst");
        repeat (4) @(negedge clk);
        check("t7_nwrites", 32'(wr_n - base), 32'd3);
        check("t7_ready_idle", 32'(in_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
